alu_issue_pipe: RTL and testbench
=================================

Name: alu_issue_pipe

Overview:
- Upstream issue/capture stage for the team's combinational 8-bit ALU (a, b, opcode -> x, 4-bit flag).
- Buffers operation requests in a small command FIFO and issues one per cycle to the ALU from a registered issue stage.
- Captures the ALU result and flags into a registered output stage with valid/ready backpressure.
- Turns the purely combinational ALU into a throughput-1, latency-2 pipelined unit.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- DW, 8, operand/result width; must match the ALU (8).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and both stages.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_a  in  DW  operand A.
- in_b  in  DW  operand B.
- in_op  in  3  ALU opcode.
- alu_a  out  DW  registered operand A to the ALU.
- alu_b  out  DW  registered operand B to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_x  in  DW  ALU result (combinational from alu_a/b/op).
- alu_flag  in  4  ALU flags: [0] sign, [1] carry, [2] zero, [3] overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_x  out  DW  captured result.
- out_flag  out  4  captured flags.
- out_op  out  3  opcode that produced out_x.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty; rd/wr pointers 0; fifo_count 0; issue-valid 0; alu_a/alu_b/alu_op 0; out_valid 0; out_x 0; out_flag 0; out_op 0. in_ready = 1 after reset release.
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- in_ready = !full. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- FIFO: push on in_valid & in_ready. Pointers wrap modulo DEPTH, with an extra MSB for full/empty. Simultaneous push and pop when non-empty: count unchanged. Push into an empty FIFO: the entry is poppable the next cycle.
- Stage advance definitions:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
- Issue stage (S1): when s1_adv, S1 loads the FIFO head (pop) if FIFO non-empty, else s1_valid <= 0. alu_a/b/op hold their last values while S1 is invalid; there is no zeroing after reset.
- Output stage (S2): when s2_adv, out_valid <= s1_valid. If s1_valid, out_x <= alu_x, out_flag <= alu_flag, out_op <= alu_op. Otherwise out_x/flag/op hold.
- Latency: request accepted at edge N -> in FIFO -> S1 at edge N+1 -> out_valid at edge N+2. Sustained throughput is 1 op/cycle with out_ready held high.
- Backpressure: out_ready low with out_valid high freezes S2. S1 freezes if valid. The FIFO keeps filling until full, then in_ready drops. No request is lost or duplicated.
- Ordering: results are delivered strictly in request order.
- flush (synchronous, higher priority than push/pop):
  - Next edge: FIFO empty, s1_valid 0, out_valid 0.
  - Data registers hold.
  - Any request presented in the flush cycle is dropped.
- Width rules: no arithmetic is performed here. Flags are passed unmodified. fifo_count ranges 0..DEPTH.

Optional Feature:
- Macro: ALU_STICKY_FLAGS_EN.
- When defined, adds:
  - input sticky_clr (1 bit).
  - output sticky_flag (4 bits, reset 0).
- On each S2 capture, sticky_flag <= sticky_flag | alu_flag.
- sticky_clr clears sticky_flag to 0 at the next edge. If sticky_clr and a capture occur in the same cycle, sticky_flag <= alu_flag.
- flush does not clear sticky_flag.
- Undefined: neither port exists and there is no sticky logic.

Decomposition:
- Shared package alu_pkg:
  - DW constant.
  - opcode localparams: ADD=000, SUB=001, SHL=010, SHR=011, AND=100, XOR=101, NOT=110, OR=111.
  - flag index constants: FLG_SIGN=0, FLG_CARRY=1, FLG_ZERO=2, FLG_OVF=3.
- One sub-module: alu_cmd_fifo. It is a synchronous FIFO of width 2*DW+3 with push/pop/flush/full/empty/count.
- S1/S2 logic lives in the top module.

Test Plan:
- Reset mid-stream: assert rst_n low with 3 entries queued and out_valid=1 -> all outputs 0 immediately; in_ready=1 after release; no stale results emerge.
- Single op: push a=0xF0, b=0x20, op=000 with out_ready=1 -> out_valid at cycle +2 with out_x=0x10, out_flag[1]=1, out_op=000.
- Streaming: 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles, in order, 1/cycle. Include:
  - op=001, a=0x05, b=0x05 -> out_x=0x00, flag[2]=1.
  - op=110, a=0x0F -> out_x=0xF0, flag[0]=1.
- Backpressure/full: out_ready=0 and 7 pushes -> in_ready drops after DEPTH+2=6 accepted and fifo_count=4. Then release out_ready -> all 6 results delivered in order, none duplicated.
- Flush: flush with FIFO=2, S1 and S2 valid, plus a concurrent push -> next cycle out_valid=0, fifo_count=0; the pushed request is never output.
- Sticky (ALU_STICKY_FLAGS_EN):
  - Capture flags 0001 then 0100 -> sticky_flag=0101.
  - sticky_clr concurrent with a capture of 0010 -> sticky_flag=0010.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings, flag bit positions and the queued command layout.
package alu_pkg;

  localparam int DW    = 8;
  localparam int FLG_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  localparam int FLG_SIGN  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_OVF   = 3;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_issue_pipe_if.sv
// Request, ALU-side and result buses of alu_issue_pipe.
// The pipe sits on the slave modport; the environment (producer, ALU and consumer) sits on the master modport.
interface alu_issue_pipe_if #(
  parameter int DW = alu_pkg::DW
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [2:0]       in_op;

  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [2:0]       alu_op;
  logic [DW-1:0]    alu_x;
  logic [FLG_W-1:0] alu_flag;

  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_x;
  logic [FLG_W-1:0] out_flag;
  logic [2:0]       out_op;

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    output in_ready,
    output alu_a, alu_b, alu_op,
    input  alu_x, alu_flag,
    output out_valid, out_x, out_flag, out_op,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_op,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    output alu_x, alu_flag,
    input  out_valid, out_x, out_flag, out_op,
    output out_ready
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with wrap-bit pointers; flush empties it and outranks push/pop.
// Latency: a push is visible at the head one edge later; push while full and pop while empty are ignored.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: command FIFO -> registered issue stage (S1) -> combinational ALU -> registered capture stage (S2).
// Latency 2 edges from accept to out_valid, 1 op/cycle; out_ready low stalls S2, then S1, then the FIFO fills and in_ready drops.
// Optional build macro ALU_STICKY_FLAGS_EN adds sticky_clr/sticky_flag, an OR-accumulation of captured flags.
module alu_issue_pipe
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = alu_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic                   sticky_clr,
  output logic [FLG_W-1:0]       sticky_flag,
`endif
  alu_issue_pipe_if.slave        bus,
  output logic [$clog2(DEPTH):0] fifo_count
);
  cmd_t             push_cmd, head_cmd;
  logic             fifo_full, fifo_empty;
  logic             push, pop, s1_adv, s2_adv, capture;

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_x_q, out_x_d;
  logic [FLG_W-1:0] out_flag_q, out_flag_d;
  logic [2:0]       out_op_q, out_op_d;

  assign push_cmd = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
  assign push     = bus.in_valid && !fifo_full;
  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign pop      = s1_adv && !fifo_empty && !flush;
  assign capture  = s2_adv && s1_valid_q && !flush;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .pop_dat  (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_flag_d  = out_flag_q;
    out_op_d    = out_op_q;
    // Flush kills the valid bits only; data registers keep their last contents.
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s2_adv) out_valid_d = s1_valid_q;
      if (capture) begin
        out_x_d    = bus.alu_x;
        out_flag_d = bus.alu_flag;
        out_op_d   = alu_op_q;
      end
      if (s1_adv) begin
        s1_valid_d = !fifo_empty;
        if (!fifo_empty) begin
          alu_a_d  = head_cmd.a;
          alu_b_d  = head_cmd.b;
          alu_op_d = head_cmd.op;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_flag_q  <= '0;
      out_op_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_flag_q  <= out_flag_d;
      out_op_q    <= out_op_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_flag  = out_flag_q;
  assign bus.out_op    = out_op_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [FLG_W-1:0] sticky_q, sticky_d;

  // Clear first, then OR in a same-cycle capture so the new flags survive the clear.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = '0;
    if (capture)    sticky_d = sticky_d | bus.alu_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flag = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Directed bench for alu_issue_pipe with a behavioural ALU on the interface; sticky checks build only with ALU_STICKY_FLAGS_EN.
module tb_alu_issue_pipe;
  import alu_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] fifo_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic       sticky_clr = 1'b0;
  logic [3:0] sticky_flag;
`endif

  int errors = 0;
  int checks = 0;
  int got;
  int seen;

  alu_issue_pipe_if #(.DW(8)) ifc ();

  alu_issue_pipe #(.DEPTH(4), .DW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr  (sticky_clr),
    .sticky_flag (sticky_flag),
`endif
    .bus         (ifc),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: 9-bit result carries the carry/borrow or shifted-out bit.
  logic [8:0] alu_r;
  logic       alu_ovf;
  always_comb begin
    alu_r = '0;
    case (ifc.alu_op)
      OP_ADD:  alu_r = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
      OP_SUB:  alu_r = {1'b0, ifc.alu_a} - {1'b0, ifc.alu_b};
      OP_SHL:  alu_r = {ifc.alu_a, 1'b0};
      OP_SHR:  alu_r = {ifc.alu_a[0], 1'b0, ifc.alu_a[7:1]};
      OP_AND:  alu_r = {1'b0, ifc.alu_a & ifc.alu_b};
      OP_XOR:  alu_r = {1'b0, ifc.alu_a ^ ifc.alu_b};
      OP_NOT:  alu_r = {1'b0, ~ifc.alu_a};
      default: alu_r = {1'b0, ifc.alu_a | ifc.alu_b};
    endcase
    alu_ovf = 1'b0;
    if (ifc.alu_op == OP_ADD)
      alu_ovf = (ifc.alu_a[7] == ifc.alu_b[7]) && (alu_r[7] != ifc.alu_a[7]);
    else if (ifc.alu_op == OP_SUB)
      alu_ovf = (ifc.alu_a[7] != ifc.alu_b[7]) && (alu_r[7] != ifc.alu_a[7]);
    ifc.alu_x    = alu_r[7:0];
    ifc.alu_flag = {alu_ovf, (alu_r[7:0] == 8'h00), alu_r[8], alu_r[7]};
  end

  // Streaming vectors with hand-computed results and flags {ovf,zero,carry,sign}.
  logic [2:0] st_op [8] = '{OP_ADD, OP_SUB, OP_NOT, OP_SHL, OP_SHR, OP_AND, OP_XOR, OP_ADD};
  logic [7:0] st_a  [8] = '{8'h01, 8'h05, 8'h0F, 8'h81, 8'h03, 8'hF0, 8'hFF, 8'h7F};
  logic [7:0] st_b  [8] = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h0F, 8'h01};
  logic [7:0] st_x  [8] = '{8'h03, 8'h00, 8'hF0, 8'h02, 8'h01, 8'h30, 8'hF0, 8'h80};
  logic [3:0] st_f  [8] = '{4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b1001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_set(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_a     = a;
    ifc.in_b     = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_op     = '0;
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_alu_a", 32'(ifc.alu_a), 32'h0);
    chk("rst_out_x", 32'(ifc.out_x), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(ifc.in_ready), 32'h1);

    // Single ADD: F0 + 20 = 110 -> x=10, carry set, valid two edges after accept.
    push_set(OP_ADD, 8'hF0, 8'h20);
    tick();
    ifc.in_valid = 1'b0;
    chk("single_cnt_n", 32'(fifo_count), 32'h1);
    chk("single_vld_n", 32'(ifc.out_valid), 32'h0);
    tick();
    chk("single_alu_a", 32'(ifc.alu_a), 32'hF0);
    chk("single_alu_b", 32'(ifc.alu_b), 32'h20);
    chk("single_vld_n1", 32'(ifc.out_valid), 32'h0);
    tick();
    chk("single_vld_n2", 32'(ifc.out_valid), 32'h1);
    chk("single_x", 32'(ifc.out_x), 32'h10);
    chk("single_flag", 32'(ifc.out_flag), 32'h2);
    chk("single_op", 32'(ifc.out_op), 32'h0);
    tick();
    chk("single_vld_n3", 32'(ifc.out_valid), 32'h0);

    // Back-to-back stream: result k appears right after the edge that accepts request k+2.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) push_set(st_op[k], st_a[k], st_b[k]);
      else       ifc.in_valid = 1'b0;
      tick();
      if (k >= 2 && k < 10) begin
        chk($sformatf("stream_vld%0d", k-2), 32'(ifc.out_valid), 32'h1);
        chk($sformatf("stream_x%0d", k-2), 32'(ifc.out_x), 32'(st_x[k-2]));
        chk($sformatf("stream_flag%0d", k-2), 32'(ifc.out_flag), 32'(st_f[k-2]));
        chk($sformatf("stream_op%0d", k-2), 32'(ifc.out_op), 32'(st_op[k-2]));
      end else begin
        chk($sformatf("stream_idle%0d", k), 32'(ifc.out_valid), 32'h0);
      end
    end

    // Backpressure: 6 accepted (S2 + S1 + 4 in FIFO), the 7th is refused.
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      push_set(OP_ADD, 8'h10 + 8'(k), 8'h01);
      chk($sformatf("bp_in_ready%0d", k), 32'(ifc.in_ready), (k < 6) ? 32'h1 : 32'h0);
      tick();
    end
    ifc.in_valid = 1'b0;
    chk("bp_count", 32'(fifo_count), 32'h4);
    chk("bp_full_ready", 32'(ifc.in_ready), 32'h0);
    chk("bp_hold_vld", 32'(ifc.out_valid), 32'h1);
    chk("bp_hold_x", 32'(ifc.out_x), 32'h11);
    ifc.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (ifc.out_valid) begin
        if (got < 6) chk($sformatf("bp_drain%0d", got), 32'(ifc.out_x), 32'(8'h11 + 8'(got)));
        got++;
      end
      tick();
    end
    chk("bp_drain_count", 32'(got), 32'h6);

    // Flush with S2, S1 and two FIFO entries live plus a concurrent push.
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_set(OP_XOR, 8'hA0 + 8'(k), 8'h0F);
      tick();
    end
    ifc.in_valid = 1'b0;
    chk("fl_pre_count", 32'(fifo_count), 32'h2);
    chk("fl_pre_vld", 32'(ifc.out_valid), 32'h1);
    chk("fl_pre_x", 32'(ifc.out_x), 32'hAF);
    flush = 1'b1;
    push_set(OP_ADD, 8'hEE, 8'h11);
    tick();
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    chk("fl_vld", 32'(ifc.out_valid), 32'h0);
    chk("fl_count", 32'(fifo_count), 32'h0);
    chk("fl_x_hold", 32'(ifc.out_x), 32'hAF);
    chk("fl_in_ready", 32'(ifc.in_ready), 32'h1);
    ifc.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifc.out_valid) seen++;
    end
    chk("fl_no_output", 32'(seen), 32'h0);

`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_clr_idle", 32'(sticky_flag), 32'h0);
    push_set(OP_NOT, 8'h0F, 8'h00);
    tick();
    push_set(OP_SUB, 8'h05, 8'h05);
    tick();
    ifc.in_valid = 1'b0;
    tick();
    tick();
    chk("sticky_accum", 32'(sticky_flag), 32'h5);
    push_set(OP_SHL, 8'h81, 8'h00);
    tick();
    ifc.in_valid = 1'b0;
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_clr_capture", 32'(sticky_flag), 32'h2);
    chk("sticky_capture_x", 32'(ifc.out_x), 32'h02);
    tick();
`endif

    // Reset mid-stream with S2 valid and three queued entries.
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_set(OP_OR, 8'h30 + 8'(k), 8'h80);
      tick();
    end
    ifc.in_valid = 1'b0;
    chk("rm_pre_count", 32'(fifo_count), 32'h3);
    chk("rm_pre_vld", 32'(ifc.out_valid), 32'h1);
    chk("rm_pre_x", 32'(ifc.out_x), 32'hB0);
    rst_n = 1'b0;
    #1;
    chk("rm_vld", 32'(ifc.out_valid), 32'h0);
    chk("rm_x", 32'(ifc.out_x), 32'h0);
    chk("rm_flag", 32'(ifc.out_flag), 32'h0);
    chk("rm_op", 32'(ifc.out_op), 32'h0);
    chk("rm_count", 32'(fifo_count), 32'h0);
    chk("rm_alu_a", 32'(ifc.alu_a), 32'h0);
    chk("rm_alu_op", 32'(ifc.alu_op), 32'h0);
`ifdef ALU_STICKY_FLAGS_EN
    chk("rm_sticky", 32'(sticky_flag), 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("rm_in_ready", 32'(ifc.in_ready), 32'h1);
    ifc.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifc.out_valid) seen++;
    end
    chk("rm_no_stale", 32'(seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
